// File: rtl/bus_pkg.sv
// Constants and types shared by bus, bus_arb and their benches.
package bus_pkg;

  localparam int DATABIT_IN   = 32;
  localparam int RAM_ADDR_BIT = 2;
  localparam int RAM_ADDR_MAX = (1 << RAM_ADDR_BIT) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a tie goes to whichever requester was not granted last.
module rr_pick (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       gnt_any,
  output logic       gnt_id
);

  // Pick the winner from the current requests and the previous grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = last;
    case (valid)
      2'b01:   begin gnt_any = 1'b1; gnt_id = 1'b0;  end
      2'b10:   begin gnt_any = 1'b1; gnt_id = 1'b1;  end
      2'b11:   begin gnt_any = 1'b1; gnt_id = ~last; end
      default: begin gnt_any = 1'b0; gnt_id = last;  end
    endcase
  end

endmodule

// File: rtl/bus_arb.sv
// Two-requester round-robin arbiter for the write port of bus; data and
// handshake pass straight through from the granted requester.
module bus_arb #(
  parameter int DATABIT_IN   = bus_pkg::DATABIT_IN,
  parameter int RAM_ADDR_BIT = bus_pkg::RAM_ADDR_BIT,
  parameter int BURST_LEN    = bus_pkg::RAM_ADDR_MAX + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATABIT_IN-1:0] s0_data,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [DATABIT_IN-1:0] s1_data,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  output logic [DATABIT_IN-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_id,
  output logic                  arb_busy
);

  import bus_pkg::*;

  localparam logic [RAM_ADDR_BIT-1:0] CNT_LAST = RAM_ADDR_BIT'(BURST_LEN - 1);
  localparam logic [RAM_ADDR_BIT-1:0] CNT_ONE  = RAM_ADDR_BIT'(1);

  arb_state_t              state_r;
  logic [RAM_ADDR_BIT-1:0] cnt_r;
  logic                    last_r;
  logic                    pick_s;
  logic                    gnt_any_s;
  logic                    gnt_id_s;

  rr_pick u_rr_pick (
    .valid   ({s1_valid, s0_valid}),
    .last    (last_r),
    .gnt_any (gnt_any_s),
    .gnt_id  (gnt_id_s)
  );

  // Decide whether the grant is up for re-evaluation this edge.
  always_comb begin
    pick_s = 1'b1;
    case (state_r)
      IDLE:    pick_s = 1'b1;
      GNT0:    pick_s = ~s0_valid | (m_ready & (cnt_r == CNT_LAST));
      GNT1:    pick_s = ~s1_valid | (m_ready & (cnt_r == CNT_LAST));
      default: pick_s = 1'b1;
    endcase
  end

  // Grant FSM, beat counter and last-granted id; release regrants in the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      last_r  <= 1'b1;
    end else if (pick_s) begin
      cnt_r <= '0;
      if (gnt_any_s) begin
        state_r <= gnt_id_s ? GNT1 : GNT0;
        last_r  <= gnt_id_s;
      end else begin
        state_r <= IDLE;
      end
    end else if (m_ready) begin
      // Holding a grant implies the owner is valid, so m_ready here is a beat.
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Pass-through muxes from the granted requester.
  always_comb begin
    m_data   = '0;
    m_valid  = 1'b0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    m_id     = last_r;
    case (state_r)
      GNT0: begin
        m_data   = s0_data;
        m_valid  = s0_valid;
        s0_ready = m_ready;
        m_id     = 1'b0;
      end
      GNT1: begin
        m_data   = s1_data;
        m_valid  = s1_valid;
        s1_ready = m_ready;
        m_id     = 1'b1;
      end
      default: begin
        m_data   = '0;
        m_valid  = 1'b0;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        m_id     = last_r;
      end
    endcase
  end

  assign arb_busy = (state_r != IDLE);

endmodule
